// File: rtl/alu_seq_if.sv
// Instruction, register-file and result signals between the ALU sequencer and its environment.
// master = instruction source / register file side, slave = alu_sequencer.
interface alu_seq_if #(
  parameter int unsigned N = 8
) ();
  logic         instr_valid;
  logic         instr_ready;
  logic [2:0]   opcode;
  logic [2:0]   dst_addr;
  logic [2:0]   src_a_addr;
  logic [2:0]   src_b_addr;
  logic         rf_read_enable;
  logic [2:0]   rf_read_addr;
  logic [N-1:0] rf_read_data;
  logic         rf_write_enable;
  logic [2:0]   rf_write_addr;
  logic [N-1:0] rf_write_data;
  logic [N-1:0] result;
  logic         zero_flag;
  logic         carry_flag;
  logic         done;

  modport master (
    output instr_valid, opcode, dst_addr, src_a_addr, src_b_addr, rf_read_data,
    input  instr_ready, rf_read_enable, rf_read_addr, rf_write_enable, rf_write_addr,
           rf_write_data, result, zero_flag, carry_flag, done
  );

  modport slave (
    input  instr_valid, opcode, dst_addr, src_a_addr, src_b_addr, rf_read_data,
    output instr_ready, rf_read_enable, rf_read_addr, rf_write_enable, rf_write_addr,
           rf_write_data, result, zero_flag, carry_flag, done
  );
endinterface

// File: rtl/alu_sequencer.sv
// Five-cycle instruction sequencer: reads two operands from an external register file,
// executes one ALU op and writes the result back. All outputs are registered.
module alu_sequencer #(
  parameter int unsigned N = 8
) (
  input logic     clk,
  input logic     rst,
  alu_seq_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_B, S_EXEC, S_WB} state_e;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  state_e       state_q, state_d;
  logic [2:0]   op_q, op_d;
  logic [2:0]   dst_q, dst_d;
  logic [2:0]   src_b_q, src_b_d;
  logic [N-1:0] opa_q, opa_d;
  logic [N-1:0] result_q, result_d;
  logic         zero_q, zero_d;
  logic         carry_q, carry_d;
  logic         ready_q, ready_d;
  logic         rd_en_q, rd_en_d;
  logic [2:0]   rd_addr_q, rd_addr_d;
  logic         wr_en_q, wr_en_d;
  logic [2:0]   wr_addr_q, wr_addr_d;
  logic [N-1:0] wr_data_q, wr_data_d;
  logic         done_q, done_d;
  logic [N:0]   sum_c, diff_c;

  // Next state, instruction latch, ALU, and next-cycle output decode
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dst_d     = dst_q;
    src_b_d   = src_b_q;
    opa_d     = opa_q;
    result_d  = result_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    sum_c     = {1'b0, opa_q} + {1'b0, bus.rf_read_data};
    diff_c    = {1'b0, opa_q} - {1'b0, bus.rf_read_data};

    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid && ready_q) begin
          state_d = S_RD_A;
          op_d    = bus.opcode;
          dst_d   = bus.dst_addr;
          src_b_d = bus.src_b_addr;
        end
      end
      S_RD_A: state_d = S_RD_B;
      S_RD_B: begin
        state_d = S_EXEC;
        opa_d   = bus.rf_read_data;
      end
      S_EXEC: begin
        state_d = S_WB;
        carry_d = 1'b0;
        unique case (op_q)
          OP_ADD: begin result_d = sum_c[N-1:0];  carry_d = sum_c[N];  end
          OP_SUB: begin result_d = diff_c[N-1:0]; carry_d = diff_c[N]; end
          OP_AND: result_d = opa_q & bus.rf_read_data;
          OP_OR:  result_d = opa_q | bus.rf_read_data;
          OP_XOR: result_d = opa_q ^ bus.rf_read_data;
          OP_MOV: result_d = opa_q;
          OP_SHL: begin result_d = {opa_q[N-2:0], 1'b0}; carry_d = opa_q[N-1]; end
          OP_NOP: result_d = '0;
          default: result_d = '0;
        endcase
        zero_d = (result_d == '0);
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Source A address comes straight from the bus since it is only needed in the cycle after accept
    ready_d   = (state_d == S_IDLE);
    rd_en_d   = (state_d == S_RD_A) || (state_d == S_RD_B);
    rd_addr_d = (state_d == S_RD_A) ? bus.src_a_addr :
                (state_d == S_RD_B) ? src_b_q : 3'd0;
    wr_en_d   = (state_d == S_WB) && (op_q != OP_NOP);
    wr_addr_d = (state_d == S_WB) ? dst_q : 3'd0;
    wr_data_d = (state_d == S_WB) ? result_d : '0;
    done_d    = (state_d == S_WB);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= 3'd0;
      dst_q     <= 3'd0;
      src_b_q   <= 3'd0;
      opa_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      ready_q   <= 1'b1;
      rd_en_q   <= 1'b0;
      rd_addr_q <= 3'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 3'd0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      dst_q     <= dst_d;
      src_b_q   <= src_b_d;
      opa_q     <= opa_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      ready_q   <= ready_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  assign bus.instr_ready     = ready_q;
  assign bus.rf_read_enable  = rd_en_q;
  assign bus.rf_read_addr    = rd_addr_q;
  assign bus.rf_write_enable = wr_en_q;
  assign bus.rf_write_addr   = wr_addr_q;
  assign bus.rf_write_data   = wr_data_q;
  assign bus.result          = result_q;
  assign bus.zero_flag       = zero_q;
  assign bus.carry_flag      = carry_q;
  assign bus.done            = done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: register-file model, transaction-level reference model,
// directed scenarios with literal expectations, then randomized instructions and resets.
module tb_alu_sequencer;
  localparam int unsigned N = 8;
  localparam int MASK = (1 << N) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_if #(.N(N)) bus ();
  alu_sequencer #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // Register file seen by the DUT: registered read, write on enabled edge
  logic [N-1:0] rf [8];
  logic         poke_en;
  logic [2:0]   poke_addr;
  logic [N-1:0] poke_data;
  int wr_cnt = 0, last_wa = 0, last_wd = 0;

  always @(posedge clk) begin
    if (bus.rf_read_enable) bus.rf_read_data <= rf[bus.rf_read_addr];
    if (bus.rf_write_enable) begin
      rf[bus.rf_write_addr] <= bus.rf_write_data;
      wr_cnt  <= wr_cnt + 1;
      last_wa <= int'(bus.rf_write_addr);
      last_wd <= int'(bus.rf_write_data);
    end
    if (poke_en) rf[poke_addr] <= poke_data;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic alu_ref(input int op, input int a, input int b, output int r, output bit c);
    c = 1'b0;
    case (op)
      0: begin r = (a + b) & MASK; c = (a + b) > MASK; end
      1: begin r = (a - b) & MASK; c = a < b; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = a;
      6: begin r = (a * 2) & MASK; c = (a * 2) > MASK; end
      default: r = 0;
    endcase
  endtask

  // Reference model: an accepted instruction is a timeline of cycles k=1..4 after accept
  int exp_rf [8];
  bit m_busy = 1'b0;
  int m_k = 0, m_op = 0, m_dst = 0, m_a = 0, m_b = 0, m_res = 0;
  bit m_carry = 1'b0;
  int e_res = 0;
  bit e_zero = 1'b0, e_carry = 1'b0;
  int acc_cnt = 0, acc_cyc = 0, done_cnt = 0, last_lat = 0;

  task automatic model_step();
    if (bus.instr_valid && bus.instr_ready && !rst) begin
      acc_cnt++;
      acc_cyc = cyc;
    end
    if (poke_en) exp_rf[poke_addr] = int'(poke_data);
    if (rst) begin
      m_busy = 1'b0; m_k = 0; e_res = 0; e_zero = 1'b0; e_carry = 1'b0;
    end else if (m_busy) begin
      m_k++;
      if (m_k == 4) begin e_res = m_res; e_zero = (m_res == 0); e_carry = m_carry; end
      if (m_k == 5) begin
        m_busy = 1'b0;
        if (m_op != 7) exp_rf[m_dst] = m_res;
      end
    end else if (bus.instr_valid) begin
      m_busy = 1'b1; m_k = 1;
      m_op = int'(bus.opcode); m_dst = int'(bus.dst_addr);
      m_a = int'(bus.src_a_addr); m_b = int'(bus.src_b_addr);
      alu_ref(m_op, exp_rf[m_a], exp_rf[m_b], m_res, m_carry);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of every output against the model
  initial forever begin
    bit wb;
    @(negedge clk);
    cyc++;
    if (bus.done) begin done_cnt++; last_lat = cyc - acc_cyc; end
    if (chk_en) begin
      wb = m_busy && (m_k == 4);
      chk("instr_ready", int'(bus.instr_ready), int'(!m_busy));
      chk("rf_read_enable", int'(bus.rf_read_enable), int'(m_busy && (m_k == 1 || m_k == 2)));
      chk("rf_read_addr", int'(bus.rf_read_addr),
          !m_busy ? 0 : (m_k == 1) ? m_a : (m_k == 2) ? m_b : 0);
      chk("rf_write_enable", int'(bus.rf_write_enable), int'(wb && m_op != 7));
      chk("rf_write_addr", int'(bus.rf_write_addr), wb ? m_dst : 0);
      chk("rf_write_data", int'(bus.rf_write_data), wb ? m_res : 0);
      chk("done", int'(bus.done), int'(wb));
      chk("result", int'(bus.result), e_res);
      chk("zero_flag", int'(bus.zero_flag), int'(e_zero));
      chk("carry_flag", int'(bus.carry_flag), int'(e_carry));
    end
  end

  task automatic poke(input int a, input int v);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = 3'(a); poke_data = N'(v);
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Present an instruction, hold until accepted; returns at the negedge of the first busy cycle
  task automatic issue(input int op, input int d, input int a, input int b);
    int n = 0;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.opcode = 3'(op); bus.dst_addr = 3'(d); bus.src_a_addr = 3'(a); bus.src_b_addr = 3'(b);
    while (!bus.instr_ready && n < 12) begin @(negedge clk); n++; end
    if (n >= 12) begin
      n_chk++; n_fail++;
      $display("FAIL issue_timeout: instr_ready stayed 0 for %0d cycles, expected 1", n);
    end
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.opcode = 3'($urandom); bus.dst_addr = 3'($urandom);
    bus.src_a_addr = 3'($urandom); bus.src_b_addr = 3'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.instr_ready && n < 20);
    if (n >= 20) begin
      n_chk++; n_fail++;
      $display("FAIL idle_timeout: instr_ready stayed 0 for %0d cycles, expected 1", n);
    end
  endtask

  initial begin
    int w0, d0, a0;
    rst = 1'b1; poke_en = 1'b0; poke_addr = 3'd0; poke_data = '0;
    bus.instr_valid = 1'b0; bus.opcode = 3'd0; bus.dst_addr = 3'd0;
    bus.src_a_addr = 3'd0; bus.src_b_addr = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_ready", int'(bus.instr_ready), 1);
    chk("reset_result", int'(bus.result), 0);
    chk("reset_zero", int'(bus.zero_flag), 0);
    chk("reset_carry", int'(bus.carry_flag), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_wr_en", int'(bus.rf_write_enable), 0);
    chk_en = 1'b1;

    for (int i = 0; i < 8; i++) poke(i, 0);
    poke(1, 8'h05); poke(2, 8'h03);

    w0 = wr_cnt;
    issue(0, 3, 1, 2); wait_idle();
    chk("add_wr_count", wr_cnt - w0, 1);
    chk("add_wr_addr", last_wa, 3);
    chk("add_wr_data", last_wd, 8'h08);
    chk("add_latency", last_lat, 4);
    chk("add_zero", int'(bus.zero_flag), 0);
    chk("add_carry", int'(bus.carry_flag), 0);

    issue(1, 4, 2, 1); wait_idle();
    chk("sub_wr_addr", last_wa, 4);
    chk("sub_wr_data", last_wd, 8'hFE);
    chk("sub_borrow", int'(bus.carry_flag), 1);

    poke(5, 8'hFF); poke(6, 8'h01);
    issue(0, 5, 5, 6); wait_idle();
    chk("wrap_wr_addr", last_wa, 5);
    chk("wrap_wr_data", last_wd, 8'h00);
    chk("wrap_zero", int'(bus.zero_flag), 1);
    chk("wrap_carry", int'(bus.carry_flag), 1);
    issue(5, 7, 5, 0); wait_idle();
    chk("mov_wr_addr", last_wa, 7);
    chk("mov_wr_data", last_wd, 8'h00);
    chk("mov_r7", int'(rf[7]), 0);

    // NOP with instr_valid held for 10 edges: two accepts, two dones, no writes
    w0 = wr_cnt; d0 = done_cnt; a0 = acc_cnt;
    @(negedge clk);
    bus.instr_valid = 1'b1; bus.opcode = 3'd7; bus.dst_addr = 3'd2;
    bus.src_a_addr = 3'd1; bus.src_b_addr = 3'd2;
    repeat (10) @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    chk("nop_writes", wr_cnt - w0, 0);
    chk("nop_dones", done_cnt - d0, 2);
    chk("nop_accepts", acc_cnt - a0, 2);
    chk("nop_result", int'(bus.result), 0);
    chk("nop_zero", int'(bus.zero_flag), 1);
    chk("nop_carry", int'(bus.carry_flag), 0);

    // Reset during RD_B aborts the instruction
    poke(1, 8'h10);
    w0 = wr_cnt; d0 = done_cnt;
    issue(0, 3, 1, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", int'(bus.instr_ready), 1);
    repeat (6) @(negedge clk);
    chk("abort_writes", wr_cnt - w0, 0);
    chk("abort_dones", done_cnt - d0, 0);
    chk("abort_r3", int'(rf[3]), 8'h08);

    for (int i = 0; i < 8; i++) poke(i, int'($urandom_range(0, MASK)));
    repeat (300) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      if ($urandom_range(0, 19) == 0) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) begin
        wait_idle();
        poke(int'($urandom_range(0, 7)), int'($urandom_range(0, MASK)));
      end
    end
    wait_idle();
    @(negedge clk);
    for (int i = 0; i < 8; i++) chk($sformatf("final_rf%0d", i), int'(rf[i]), exp_rf[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
